// File: rtl/jt51_ch_wr_sched.sv
// Channel-register write scheduler: decodes CPU writes to 0x20-0x3F, queues them,
// and releases each one when its channel reaches the register file's input stage.
module jt51_ch_wr_sched #(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       wr,
  input  logic [7:0] addr,
  input  logic [7:0] din,
  input  logic       clr_ovf,
  output logic [7:0] ch_din,
  output logic       up_rl_ch,
  output logic       up_fb_ch,
  output logic       up_con_ch,
  output logic       up_kc_ch,
  output logic       up_kf_ch,
  output logic       up_ams_ch,
  output logic       up_pms_ch,
  output logic [2:0] cur_ch,
  output logic       busy,
  output logic       ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    T_RFC = 2'd0,
    T_KC  = 2'd1,
    T_KF  = 2'd2,
    T_AP  = 2'd3
  } wr_type_e;

  typedef struct packed {
    wr_type_e   typ;
    logic [2:0] ch;
    logic [7:0] data;
  } entry_t;

  logic [2:0]    cur_ch_q, cur_ch_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  entry_t        mem_q [DEPTH];

  entry_t head;
  entry_t new_entry;
  logic   dec_hit;
  logic   full;
  logic   empty;
  logic   issue;
  logic   push;
  logic   drop;

  // 0x20-0x3F: addr[4:3] selects the register group, addr[2:0] the channel
  always_comb begin
    dec_hit        = (addr[7:5] == 3'b001);
    new_entry.typ  = wr_type_e'(addr[4:3]);
    new_entry.ch   = addr[2:0];
    new_entry.data = din;
  end

  always_comb begin
    full  = (count_q == CW'(DEPTH));
    empty = (count_q == '0);
    head  = mem_q[rd_ptr_q];
    issue = !empty && cen && (cur_ch_q == head.ch);
    // A pop on the same edge frees the slot the new write needs
    push  = wr && dec_hit && (!full || issue);
    drop  = wr && dec_hit && full && !issue;
  end

  always_comb begin
    cur_ch_d = cen ? cur_ch_q + 3'd1 : cur_ch_q;
    rd_ptr_d = issue ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    count_d  = count_q;
    case ({push, issue})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_ch_q <= 3'd0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      cur_ch_q <= cur_ch_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= new_entry;
    end
  end

  always_comb begin
    ch_din    = empty ? 8'd0 : head.data;
    up_rl_ch  = 1'b0;
    up_fb_ch  = 1'b0;
    up_con_ch = 1'b0;
    up_kc_ch  = 1'b0;
    up_kf_ch  = 1'b0;
    up_ams_ch = 1'b0;
    up_pms_ch = 1'b0;
    if (issue) begin
      case (head.typ)
        T_RFC: begin
          up_rl_ch  = 1'b1;
          up_fb_ch  = 1'b1;
          up_con_ch = 1'b1;
        end
        T_KC: up_kc_ch = 1'b1;
        T_KF: up_kf_ch = 1'b1;
        T_AP: begin
          up_ams_ch = 1'b1;
          up_pms_ch = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign cur_ch = cur_ch_q;
  assign busy   = full;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_jt51_ch_wr_sched.sv
// Bench for jt51_ch_wr_sched: directed scenarios plus random traffic against a queue model.
module tb_jt51_ch_wr_sched;

  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cen = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] addr = 8'd0;
  logic [7:0] din = 8'd0;
  logic       clr_ovf = 1'b0;
  logic [7:0] ch_din;
  logic       up_rl_ch, up_fb_ch, up_con_ch, up_kc_ch, up_kf_ch, up_ams_ch, up_pms_ch;
  logic [2:0] cur_ch;
  logic       busy;
  logic       ovf;

  int checks = 0;
  int errors = 0;

  jt51_ch_wr_sched #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .wr(wr), .addr(addr), .din(din),
    .clr_ovf(clr_ovf), .ch_din(ch_din),
    .up_rl_ch(up_rl_ch), .up_fb_ch(up_fb_ch), .up_con_ch(up_con_ch),
    .up_kc_ch(up_kc_ch), .up_kf_ch(up_kf_ch), .up_ams_ch(up_ams_ch),
    .up_pms_ch(up_pms_ch), .cur_ch(cur_ch), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of pending register writes
  typedef struct {
    int         kind;  // 0 RL/FB/CON, 1 KC, 2 KF, 3 AMS/PMS
    int         ch;
    logic [7:0] data;
  } ent_t;

  ent_t m_q[$];
  int   m_cur = 0;
  bit   m_ovf = 1'b0;

  function automatic logic [6:0] kind_mask(int k);
    case (k)
      0:       return 7'b1110000;
      1:       return 7'b0001000;
      2:       return 7'b0000100;
      default: return 7'b0000011;
    endcase
  endfunction

  // {rl,fb,con,kc,kf,ams,pms, ch_din, cur_ch, busy, ovf}
  function automatic logic [19:0] exp_vec();
    logic [6:0] m = 7'd0;
    logic [7:0] d = 8'd0;
    if (m_q.size() > 0) begin
      d = m_q[0].data;
      if (cen && m_q[0].ch == m_cur) m = kind_mask(m_q[0].kind);
    end
    return {m, d, 3'(m_cur), (m_q.size() == DEPTH), m_ovf};
  endfunction

  function automatic logic [19:0] obs_vec();
    return {up_rl_ch, up_fb_ch, up_con_ch, up_kc_ch, up_kf_ch, up_ams_ch, up_pms_ch,
            ch_din, cur_ch, busy, ovf};
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_cur = 0;
    m_ovf = 1'b0;
  endfunction

  task automatic apply(input logic w, input logic [7:0] a, input logic [7:0] d,
                       input logic c, input logic clr);
    @(negedge clk);
    wr = w; addr = a; din = d; cen = c; clr_ovf = clr;
    #1;
  endtask

  task automatic advance();
    bit   pop, dec, dropped;
    ent_t e;
    pop = (m_q.size() > 0) && cen && (m_q[0].ch == m_cur);
    dec = wr && (addr >= 8'h20) && (addr <= 8'h3F);
    e.kind = (int'(addr) - 32) / 8;
    e.ch   = int'(addr) % 8;
    e.data = din;
    dropped = 1'b0;
    @(posedge clk);
    if (pop) void'(m_q.pop_front());
    if (dec) begin
      if (m_q.size() < DEPTH) m_q.push_back(e);
      else dropped = 1'b1;
    end
    if (dropped) m_ovf = 1'b1;
    else if (clr_ovf) m_ovf = 1'b0;
    if (cen) m_cur = (m_cur + 1) % 8;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (obs_vec() !== 20'd0) begin
      errors++; $display("FAIL reset_state got=%h exp=%h", obs_vec(), 20'd0);
    end
    #11 rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 9; i++) begin
      apply(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      checks++;
      if (cur_ch !== 3'(i % 8)) begin
        errors++; $display("FAIL reset_count i=%0d got=%0d exp=%0d", i, cur_ch, i % 8);
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL reset_idle i=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
      advance();
    end
  endtask

  task automatic test_kc();
    int fires = 0, fire_cur = -1;
    logic [7:0] fire_din = 8'h00;
    for (int i = 0; i < 16 && m_cur != 2; i++) begin
      apply(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      advance();
    end
    apply(1'b1, 8'h2D, 8'h55, 1'b1, 1'b0);
    advance();
    for (int i = 0; i < 10; i++) begin
      apply(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL kc_cycle i=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
      if (up_kc_ch === 1'b1) begin
        fires++; fire_cur = int'(cur_ch); fire_din = ch_din;
      end
      advance();
    end
    checks++;
    if (fires != 1 || fire_cur != 5 || fire_din !== 8'h55) begin
      errors++;
      $display("FAIL kc_issue got fires=%0d cur=%0d din=%h exp fires=1 cur=5 din=55",
               fires, fire_cur, fire_din);
    end
  endtask

  task automatic test_rfc();
    int fires = 0, fire_cur = -1;
    logic [6:0] fire_mask = 7'd0;
    logic [7:0] fire_din = 8'h00;
    apply(1'b1, 8'h20, 8'hC7, 1'b1, 1'b0);
    advance();
    for (int i = 0; i < 10; i++) begin
      apply(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL rfc_cycle i=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
      if (obs_vec() >> 13 != 0) begin
        fires++; fire_cur = int'(cur_ch); fire_din = ch_din; fire_mask = 7'(obs_vec() >> 13);
      end
      advance();
    end
    checks++;
    if (fires != 1 || fire_cur != 0 || fire_din !== 8'hC7 || fire_mask !== 7'b1110000) begin
      errors++;
      $display("FAIL rfc_issue got fires=%0d cur=%0d din=%h mask=%b exp 1/0/c7/1110000",
               fires, fire_cur, fire_din, fire_mask);
    end
  endtask

  task automatic test_back_to_back();
    int kf_cur = -1, ap_cur = -1, kf_t = -1, ap_t = -1, kc_fires = 0;
    logic [7:0] kf_din = 8'h00, ap_din = 8'h00;
    apply(1'b1, 8'h37, 8'hFC, 1'b0, 1'b0);
    advance();
    apply(1'b1, 8'h3A, 8'h41, 1'b0, 1'b0);
    advance();
    apply(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL b2b_busy got=%b exp=1", busy);
    end
    advance();
    apply(1'b1, 8'h28, 8'h00, 1'b0, 1'b0);
    advance();
    apply(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    checks++;
    if (ovf !== 1'b1) begin
      errors++; $display("FAIL b2b_ovf_set got=%b exp=1", ovf);
    end
    advance();
    for (int i = 0; i < 20; i++) begin
      apply(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL b2b_cycle i=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
      if (up_kf_ch === 1'b1) begin kf_cur = int'(cur_ch); kf_din = ch_din; kf_t = i; end
      if (up_ams_ch === 1'b1 && up_pms_ch === 1'b1) begin
        ap_cur = int'(cur_ch); ap_din = ch_din; ap_t = i;
      end
      if (up_kc_ch === 1'b1) kc_fires++;
      advance();
    end
    checks++;
    if (kf_cur != 7 || kf_din !== 8'hFC) begin
      errors++; $display("FAIL b2b_kf got cur=%0d din=%h exp cur=7 din=fc", kf_cur, kf_din);
    end
    checks++;
    if (ap_cur != 2 || ap_din !== 8'h41 || ap_t <= kf_t) begin
      errors++;
      $display("FAIL b2b_ap got cur=%0d din=%h t=%0d kf_t=%0d exp cur=2 din=41 after kf",
               ap_cur, ap_din, ap_t, kf_t);
    end
    checks++;
    if (kc_fires != 0) begin
      errors++; $display("FAIL b2b_dropped_kc got fires=%0d exp=0", kc_fires);
    end
    apply(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    advance();
    apply(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    checks++;
    if (ovf !== 1'b0) begin
      errors++; $display("FAIL b2b_ovf_clr got=%b exp=0", ovf);
    end
    advance();
  endtask

  task automatic test_same_edge_pop();
    apply(1'b1, 8'h28 + 8'(m_cur), 8'h11, 1'b0, 1'b0);
    advance();
    apply(1'b1, 8'h30 + 8'((m_cur + 4) % 8), 8'h22, 1'b0, 1'b0);
    advance();
    apply(1'b1, 8'h39, 8'hA5, 1'b1, 1'b0);
    checks++;
    if (up_kc_ch !== 1'b1 || ch_din !== 8'h11 || busy !== 1'b1) begin
      errors++; $display("FAIL pop_push_issue got kc=%b din=%h busy=%b exp 1/11/1",
                         up_kc_ch, ch_din, busy);
    end
    advance();
    apply(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    checks++;
    if (busy !== 1'b1 || ovf !== 1'b0) begin
      errors++; $display("FAIL pop_push_after got busy=%b ovf=%b exp 1/0", busy, ovf);
    end
    advance();
    for (int i = 0; i < 20; i++) begin
      apply(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL pop_push_drain i=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
      advance();
    end
  endtask

  task automatic test_ignored();
    apply(1'b1, 8'h08, 8'h5A, 1'b0, 1'b0);
    advance();
    apply(1'b1, 8'h60, 8'hA5, 1'b0, 1'b0);
    advance();
    apply(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    checks++;
    if (busy !== 1'b0 || ovf !== 1'b0 || ch_din !== 8'h00) begin
      errors++; $display("FAIL ignored_push got busy=%b ovf=%b din=%h exp 0/0/00",
                         busy, ovf, ch_din);
    end
    advance();
    for (int i = 0; i < 10; i++) begin
      apply(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      checks++;
      if (obs_vec() >> 13 != 0) begin
        errors++; $display("FAIL ignored_strobe i=%0d got=%h exp=00", i, obs_vec() >> 13);
      end
      advance();
    end
  endtask

  task automatic test_async_reset();
    apply(1'b1, 8'h28 + 8'((m_cur + 3) % 8), 8'h99, 1'b0, 1'b0);
    advance();
    apply(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (cur_ch !== 3'd0 || busy !== 1'b0 || ch_din !== 8'h00 || obs_vec() !== 20'd0) begin
      errors++; $display("FAIL async_reset got=%h exp=%h", obs_vec(), 20'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      apply(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec() || up_kc_ch !== 1'b0) begin
        errors++; $display("FAIL async_reset_after i=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(0, 9) < 4),
            8'($urandom_range(8'h18, 8'h47)),
            8'($urandom),
            ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 19) == 0));
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL random i=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_kc();
    test_rfc();
    test_back_to_back();
    test_same_edge_pop();
    test_ignored();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jt51_ch_wr_sched.md
Name: jt51_ch_wr_sched

Overview:
- Schedules CPU writes to the per-channel register file. That file is an 8-stage rotating shift register, advanced on `cen`, holding RL/FB/CON/KC/KF/AMS/PMS for channels 0-7.
- The block decodes channel-register addresses and buffers writes in a 2-entry FIFO.
- It emits the matching `up_*_ch` strobe and data only during the `cen` cycle in which the target channel occupies the register file's input stage.
- It sits between the CPU interface/address decoder and the channel register file, and also owns the channel slot counter.

Parameters:
DEPTH, 2, FIFO entries (power of two, minimum 2)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
cen  input  1  clock enable; slot counter and register file advance only when high
wr  input  1  CPU write strobe, one clk cycle per write
addr  input  8  CPU register address
din  input  8  CPU write data
ch_din  output  8  data presented to the channel register file
up_rl_ch  output  1  update RL (din[7:6])
up_fb_ch  output  1  update FB (din[5:3])
up_con_ch  output  1  update CON (din[2:0])
up_kc_ch  output  1  update KC (din[6:0])
up_kf_ch  output  1  update KF (din[7:2])
up_ams_ch  output  1  update AMS (din[1:0])
up_pms_ch  output  1  update PMS (din[6:4])
cur_ch  output  3  channel currently at the register-file input stage
busy  output  1  FIFO full
ovf  output  1  sticky: a channel write was dropped
clr_ovf  input  1  synchronous clear of ovf

Behaviour:
- Reset (async, rst_n=0):
  - cur_ch=0, FIFO empty, ovf=0.
  - All up_* outputs are 0 and ch_din=0 while the FIFO is empty.
- Slot counter:
  - cur_ch increments by 1 on every clk edge with cen=1; wraps 7->0.
  - Unaffected by writes.
- Address decode; addr[2:0] is the channel:
  - 0x20-0x27 -> type RFC (RL, FB and CON strobes together).
  - 0x28-0x2F -> KC.
  - 0x30-0x37 -> KF.
  - 0x38-0x3F -> type AP (AMS and PMS together).
  - Any other address is ignored: no push, no ovf.
- Push:
  - On a clk edge with wr=1, a decoded address, and (FIFO not full or a pop occurring on the same edge), {type[1:0], ch[2:0], data[7:0]} is written at the tail.
  - A decoded write with the FIFO full and no pop is dropped and sets ovf=1.
  - If clr_ovf and a drop coincide, the set wins.
- Issue (combinational):
  - Condition: head valid, cen=1, and cur_ch == head.ch.
  - Drive ch_din = head.data and assert the strobe(s) for head.type.
  - Otherwise all up_*=0 and ch_din holds head.data, or 0 when empty.
- Pop: on the same clk edge where issue is true. The register file samples on that edge.
- Latency:
  - A pushed entry is visible at the head no earlier than the cycle after acceptance.
  - Issue occurs at the first following cen cycle with a matching cur_ch.
  - An entry at head waits at most 8 cen cycles.
- Ordering: strictly FIFO; a head waiting for its channel blocks later entries, even if those target the current channel.
- Merging: none. Two writes to the same register issue as two separate updates, in order.
- Simultaneous push and pop: occupancy is unchanged; both take effect.
- Pointers: wrap modulo DEPTH. `busy` is high exactly when occupancy == DEPTH.
- cen held low: nothing issues and the counter holds; writes may still fill the FIFO.
- Reset mid-operation: pending entries are discarded and no strobe is emitted.

Test Plan:
- Reset, then cen=1 continuously → cur_ch counts 0..7,0; all up_*=0; busy=0; ovf=0.
- With cur_ch=2, write addr=0x2D, din=0x55 → up_kc_ch=1 and ch_din=0x55 for exactly one cen cycle, when cur_ch==5 (3 cen cycles later); FIFO then empty.
- Write addr=0x20, din=0xC7 → up_rl_ch, up_fb_ch and up_con_ch high together when cur_ch==0; other strobes low.
- Two writes back-to-back, 0x37=0xFC then 0x3A=0x41, with cen low → busy=1. A third write, 0x28, sets ovf=1 and is never issued. After cen resumes:
  - up_kf_ch fires at cur_ch==7 with 0xFC.
  - up_ams_ch and up_pms_ch then fire at cur_ch==2 with 0x41.
  - clr_ovf then clears ovf.
- Full FIFO with the head issuing on the same edge as a new wr → write accepted, busy stays 1, ovf stays 0.
- Pending entry, then rst_n pulsed low asynchronously → no strobe ever issued; cur_ch=0 immediately; FIFO empty.
- Writes to 0x08 and 0x60 → no push, no strobe, no ovf.
